deinterleaver: RTL and testbench

//  Turbo-decoder-side inverse of the QPP interleaver; bit-serial, single block in flight per bank.
//  - Accepts a block of K bits in interleaved order c'(i) = c(pi(i)).
//  - Emits the block in natural order c(0..K-1).
//  - Ping-pong RAM banks: one block fills while the other drains.
//  - K = 1056 (small) or 6144 (large), chosen per block.

---
 rtl/deint_pkg.sv | 27 ++
 rtl/qpp_addr_gen.sv | 66 ++++++
 rtl/deinterleaver.sv | 190 +++++++++++++++++++
 tb/tb_deinterleaver.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deint_pkg.sv
// Shared constants and state types for the QPP deinterleaver.
// Holds the LTE QPP coefficients for the two supported block sizes.
package deint_pkg;

  localparam int ADDR_W   = 13;
  localparam int K_SMALL  = 1056;
  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int K_LARGE  = 6144;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rd_state_t;

  function automatic logic [ADDR_W-1:0] k_last(input logic bs);
    return bs ? ADDR_W'(K_LARGE - 1) : ADDR_W'(K_SMALL - 1);
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Multiplier-free QPP address generator: pi(i) by first/second differences.
// init and step together yield pi(1), so a start transfer can write pi(0)=0.
module qpp_addr_gen #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              step,
  input  logic              blocksize,
  output logic [ADDR_W-1:0] pi
);
  import deint_pkg::*;

  logic              bs_q;
  logic              bs;
  logic [ADDR_W-1:0] g_q;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] g0;
  logic [ADDR_W-1:0] d2;
  logic [ADDR_W-1:0] pi_b;
  logic [ADDR_W-1:0] g_b;
  logic [ADDR_W-1:0] pi_n;
  logic [ADDR_W-1:0] g_n;

  function automatic logic [ADDR_W-1:0] add_mod(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] b,
    input logic [ADDR_W-1:0] m
  );
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[ADDR_W-1:0];
  endfunction

  assign bs = init ? blocksize : bs_q;

  always_comb begin
    k    = bs ? ADDR_W'(K_LARGE) : ADDR_W'(K_SMALL);
    g0   = bs ? ADDR_W'(F1_LARGE + F2_LARGE)
              : ADDR_W'(F1_SMALL + F2_SMALL);
    d2   = bs ? ADDR_W'(2 * F2_LARGE) : ADDR_W'(2 * F2_SMALL);
    pi_b = init ? '0 : pi;
    g_b  = init ? g0 : g_q;
    pi_n = pi_b;
    g_n  = g_b;
    if (step) begin
      pi_n = add_mod(pi_b, g_b, k);
      g_n  = add_mod(g_b, d2, k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pi   <= '0;
      g_q  <= '0;
      bs_q <= 1'b0;
    end else begin
      pi   <= pi_n;
      g_q  <= g_n;
      bs_q <= bs;
    end
  end

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong QPP deinterleaver: fill one bank in pi order, drain the other.
// Define DEINT_ERR_EN to add the err pulse for truncated blocks and overruns.
module deinterleaver #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic              in_blocksize,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              out_start,
  output logic              out_blocksize,
`ifdef DEINT_ERR_EN
  output logic              err,
`endif
  output logic              done
);
  import deint_pkg::*;

  localparam int DEPTH = K_LARGE;

  wr_state_t wr_state;
  wr_state_t wr_next;
  rd_state_t rd_state;
  rd_state_t rd_next;

  logic [1:0]        full;
  logic [1:0]        bsz;
  logic              wr_bank;
  logic              rd_bank;
  logic              rd_sel;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] pi;
  logic [ADDR_W-1:0] wr_addr;
  logic              xfer;
  logic              start_x;
  logic              wr_en;
  logic              wr_last;
  logic              fill_done;
  logic              rd_en;
  logic              rd_last;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;

  assign in_ready = ~full[wr_bank];
  assign xfer     = in_valid & in_ready;
  assign start_x  = xfer & in_start;
  assign wr_last  = (wr_cnt == k_last(bsz[wr_bank]));
  assign wr_addr  = start_x ? '0 : pi;

  qpp_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_gen (
    .clk      (clk),
    .reset    (reset),
    .init     (start_x),
    .step     (wr_en),
    .blocksize(in_blocksize),
    .pi       (pi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE:  if (start_x) wr_next = W_FILL;
      W_FILL:  if (fill_done) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    fill_done = 1'b0;
    unique case (wr_state)
      W_IDLE: wr_en = start_x;
      W_FILL: begin
        wr_en     = xfer;
        fill_done = xfer & ~in_start & wr_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      bsz     <= '0;
    end else begin
      if (start_x) begin
        wr_cnt       <= ADDR_W'(1);
        bsz[wr_bank] <= in_blocksize;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
      end
      if (fill_done) wr_bank <= ~wr_bank;
    end
  end

  // Set and clear always hit different banks, so both land together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (fill_done) full[wr_bank] <= 1'b1;
      if (rd_last)   full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (full[rd_bank]) rd_next = R_DRAIN;
      R_DRAIN: if (rd_last && !full[~rd_bank]) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (rd_state == R_DRAIN);
    rd_last = rd_en & (rd_cnt == k_last(bsz[rd_bank]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      if (rd_last)    rd_cnt <= '0;
      else if (rd_en) rd_cnt <= rd_cnt + ADDR_W'(1);
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= data_in;
    if (rd_en && !rd_bank) q0 <= mem0[rd_cnt];
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_bank) mem1[wr_addr] <= data_in;
    if (rd_en && rd_bank) q1 <= mem1[rd_cnt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_start     <= 1'b0;
      done          <= 1'b0;
      out_blocksize <= 1'b0;
      rd_sel        <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_start <= rd_en & (rd_cnt == '0);
      done      <= rd_last;
      rd_sel    <= rd_bank;
      if (rd_en) out_blocksize <= bsz[rd_bank];
    end
  end

  assign data_out = out_valid ? (rd_sel ? q1 : q0) : '0;

`ifdef DEINT_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= (start_x & (wr_state == W_FILL))
                    | (in_valid & ~in_ready);
  end
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver: single-bit probes, ping-pong streaming,
// aborted block and reset during drain, against a direct-formula QPP model.
`timescale 1ns/1ps
module tb_deinterleaver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_start = 1'b0;
  logic       in_blocksize = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] data_in = '0;
  logic       in_ready;
  logic [0:0] data_out;
  logic       out_valid;
  logic       out_start;
  logic       out_blocksize;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_cnt = 0;

  bit q_d[$];
  bit q_s[$];
  bit q_dn[$];
  bit q_b[$];
  int q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  deinterleaver #(
    .DATA_W(1),
    .ADDR_W(13)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_start     (in_start),
    .in_blocksize (in_blocksize),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_start    (out_start),
    .out_blocksize(out_blocksize),
`ifdef DEINT_ERR_EN
    .err          (err),
`endif
    .done         (done)
  );

`ifndef DEINT_ERR_EN
  assign err = 1'b0;
`endif

  always @(negedge clk) begin
    if (out_valid) begin
      q_d.push_back(data_out[0]);
      q_s.push_back(out_start);
      q_dn.push_back(done);
      q_b.push_back(out_blocksize);
      q_c.push_back(cyc);
    end
    if (err === 1'b1) err_cnt++;
  end

  function automatic int qpp(input int i, input bit bs);
    longint k, f1, f2, li;
    k  = bs ? 6144 : 1056;
    f1 = bs ? 263 : 17;
    f2 = bs ? 480 : 66;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  function automatic bit sym(input int seed, input int one_at, input int i);
    if (one_at >= 0) return (i == one_at);
    return ((i * 13 + seed * 7) % 11) < 5;
  endfunction

  function automatic int mism(input int base, input bit bs,
                              input int seed, input int one_at);
    bit e [6144];
    int k, m;
    k = bs ? 6144 : 1056;
    m = 0;
    if (base + k > q_d.size()) return k;
    for (int i = 0; i < k; i++) e[qpp(i, bs)] = sym(seed, one_at, i);
    for (int j = 0; j < k; j++) if (q_d[base + j] != e[j]) m++;
    return m;
  endfunction

  function automatic int n_starts();
    int n = 0;
    foreach (q_s[j]) if (q_s[j]) n++;
    return n;
  endfunction

  function automatic int n_dones();
    int n = 0;
    foreach (q_dn[j]) if (q_dn[j]) n++;
    return n;
  endfunction

  function automatic int first_one();
    foreach (q_d[j]) if (q_d[j]) return j;
    return -1;
  endfunction

  function automatic int n_ones();
    int n = 0;
    foreach (q_d[j]) if (q_d[j]) n++;
    return n;
  endfunction

  task automatic clear_q();
    q_d.delete();
    q_s.delete();
    q_dn.delete();
    q_b.delete();
    q_c.delete();
    err_cnt = 0;
  endtask

  task automatic send(input bit bs, input int n, input int seed,
                      input int one_at, output int last_cyc,
                      output bit stalled);
    int w;
    stalled  = 1'b0;
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      in_start     = (i == 0);
      in_blocksize = bs;
      data_in[0]   = sym(seed, one_at, i);
      w = 0;
      while (!in_ready && w < 10000) begin
        stalled = 1'b1;
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        total++;
        bad++;
        $display("FAIL send_ready: in_ready=0 want 1 after %0d cycles", w);
        return;
      end
      last_cyc = cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid   = 1'b0;
    in_start   = 1'b0;
    data_in[0] = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int b = 0;
    while (q_d.size() < n && b < 20000) begin
      @(negedge clk);
      b++;
    end
    total++;
    if (q_d.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: got %0d outputs want %0d", name, q_d.size(), n);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_start !== 1'b0) begin
      bad++; $display("FAIL rst_out_start: got %b want 0", out_start);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %b want 0", done);
    end
    total++;
    if (data_out !== 1'b0) begin
      bad++; $display("FAIL rst_data_out: got %b want 0", data_out);
    end
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL rst_err: got %b want 0", err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_bit(input bit bs, input int one_at,
                                 input int exp_idx, input string name);
    int k, lc, v;
    bit st;
    k = bs ? 6144 : 1056;
    clear_q();
    send(bs, k, 0, one_at, lc, st);
    idle();
    wait_out(k, name);
    total++;
    if (q_d.size() != k) begin
      bad++; $display("FAIL %s_count: got %0d want %0d", name, q_d.size(), k);
    end
    v = first_one();
    total++;
    if (v != exp_idx) begin
      bad++; $display("FAIL %s_index: got %0d want %0d", name, v, exp_idx);
    end
    v = n_ones();
    total++;
    if (v != 1) begin
      bad++; $display("FAIL %s_ones: got %0d want 1", name, v);
    end
    if (q_d.size() >= k) begin
      total++;
      if (q_s[0] !== 1'b1 || n_starts() != 1) begin
        bad++; $display("FAIL %s_start: got %b/%0d want 1/1", name, q_s[0], n_starts());
      end
      total++;
      if (q_dn[k-1] !== 1'b1 || n_dones() != 1) begin
        bad++; $display("FAIL %s_done: got %b/%0d want 1/1", name, q_dn[k-1], n_dones());
      end
      total++;
      if (q_b[0] !== bs || q_b[k-1] !== bs) begin
        bad++; $display("FAIL %s_blocksize: got %b want %b", name, q_b[0], bs);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1, n2, gaps, m;
    bit s0, s1, s2;
    clear_q();
    send(1'b0, 1056, 1, -1, n0, s0);
    send(1'b0, 1056, 2, -1, n1, s1);
    send(1'b0, 1056, 3, -1, n2, s2);
    idle();
    wait_out(3168, "b2b");
    total++;
    if ((s0 | s1 | s2) !== 1'b1) begin
      bad++; $display("FAIL b2b_stall: in_ready low seen=%b want 1", s0 | s1 | s2);
    end
    total++;
    if (q_d.size() != 3168) begin
      bad++; $display("FAIL b2b_count: got %0d want 3168", q_d.size());
    end
    if (q_d.size() >= 3168) begin
      total++;
      if (q_c[0] - n0 != 3) begin
        bad++; $display("FAIL b2b_latency: got %0d want 3", q_c[0] - n0);
      end
      for (int b = 0; b < 3; b++) begin
        m = mism(b * 1056, 1'b0, b + 1, -1);
        total++;
        if (m != 0) begin
          bad++; $display("FAIL b2b_block%0d: got %0d mismatches want 0", b, m);
        end
      end
      gaps = 0;
      for (int j = 1; j < 3168; j++)
        if (j % 1056 != 0 && q_c[j] != q_c[j-1] + 1) gaps++;
      total++;
      if (gaps != 0) begin
        bad++; $display("FAIL b2b_gaps_in_block: got %0d want 0", gaps);
      end
      total++;
      if (q_c[1056] != q_c[1055] + 1) begin
        bad++; $display("FAIL b2b_gapless_switch: got %0d want %0d", q_c[1056], q_c[1055] + 1);
      end
      total++;
      if (n_starts() != 3 || n_dones() != 3) begin
        bad++; $display("FAIL b2b_flags: got %0d/%0d want 3/3", n_starts(), n_dones());
      end
    end
  endtask

  task automatic test_abort();
    int lc, m, exp_err;
    bit st;
    clear_q();
    send(1'b1, 500, 4, -1, lc, st);
    send(1'b0, 1056, 5, -1, lc, st);
    idle();
    wait_out(1056, "abort");
    repeat (100) @(negedge clk);
    total++;
    if (q_d.size() != 1056) begin
      bad++; $display("FAIL abort_count: got %0d want 1056", q_d.size());
    end
    m = mism(0, 1'b0, 5, -1);
    total++;
    if (m != 0) begin
      bad++; $display("FAIL abort_data: got %0d mismatches want 0", m);
    end
    if (q_b.size() > 0) begin
      total++;
      if (q_b[0] !== 1'b0) begin
        bad++; $display("FAIL abort_blocksize: got %b want 0", q_b[0]);
      end
    end
`ifdef DEINT_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    total++;
    if (err_cnt != exp_err) begin
      bad++; $display("FAIL abort_err: got %0d pulses want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    int lc, b, v;
    bit st;
    clear_q();
    send(1'b0, 1056, 6, -1, lc, st);
    idle();
    b = 0;
    while (q_d.size() < 100 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    send(1'b0, 1056, 0, 2, lc, st);
    idle();
    wait_out(1056, "midrst");
    repeat (100) @(negedge clk);
    total++;
    if (q_d.size() != 1056) begin
      bad++; $display("FAIL midrst_count: got %0d want 1056", q_d.size());
    end
    v = first_one();
    total++;
    if (v != 298) begin
      bad++; $display("FAIL midrst_index: got %0d want 298", v);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit(1'b0, 1, 83, "small_i1");
    test_single_bit(1'b0, 2, 298, "small_i2");
    test_single_bit(1'b1, 1, 743, "large_i1");
    test_back_to_back();
    test_abort();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
